// File: rtl/pipelined_cascade_reduce_if.sv
// Streaming bus for the pipelined cascade reducer: an input beat channel
// (word + operator) and a result channel (y, break index, operator echo),
// each with its own valid/ready pair.
interface pipelined_cascade_reduce_if #(
    parameter int LENGTH = 8
);
    localparam int IW = $clog2(LENGTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [LENGTH-1:0] in_data;
    logic [1:0]        in_mode;

    logic              out_valid;
    logic              out_ready;
    logic              out_y;
    logic [IW-1:0]     out_idx;
    logic [1:0]        out_mode;

    // Producer of beats / consumer of results
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_y, out_idx, out_mode
    );

    // The reducer itself
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_y, out_idx, out_mode
    );
endinterface

// File: rtl/pipelined_cascade_reduce.sv
// Pipelined bit-cascade reducer. A LENGTH-bit word is folded with AND, OR,
// XOR or XNOR, SEG bits per pipeline stage, lowest bit first. For AND/OR the
// index of the first bit that breaks the cascade is tracked alongside the
// accumulator. Each stage holds one beat; a stage may load when it is empty
// or when the stage after it is loading too, so the pipeline stalls as a
// whole behind out_ready without dropping or duplicating beats.
module pipelined_cascade_reduce #(
    parameter int LENGTH = 8,
    parameter int SEG    = 4
) (
    input  logic clk,
    input  logic rst_n,
    pipelined_cascade_reduce_if.slave bus
);
    localparam int STAGES = (LENGTH + SEG - 1) / SEG;
    localparam int IW     = $clog2(LENGTH + 1);

    localparam logic [1:0] MODE_AND  = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_XNOR = 2'b11;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : stage_g
            // Bit window handled here; the final stage may own fewer than SEG bits.
            localparam int LO  = gi * SEG;
            localparam int NB  = ((LENGTH - LO) < SEG) ? (LENGTH - LO) : SEG;
            localparam int REM = LENGTH - LO - NB;

            // Beat arriving at this stage: bits not yet folded plus partial state
            logic [LENGTH-LO-1:0] din;
            logic                 valid_in;
            logic [1:0]           mode_in;
            logic                 acc_in;
            logic                 found_in;
            logic [IW-1:0]        idx_in;

            // Stage registers
            logic                 valid_q;
            logic [1:0]           mode_q;
            logic                 acc_q;
            logic [IW-1:0]        idx_q;

            // Fold results and the value actually loaded into idx_q
            logic                 acc_d;
            logic                 found_d;
            logic [IW-1:0]        idx_d;
            logic [IW-1:0]        idx_load;

            logic                 ready;

            if (gi == 0) begin : head_g
                // First stage starts every beat from the operator's identity
                assign din      = bus.in_data;
                assign valid_in = bus.in_valid;
                assign mode_in  = bus.in_mode;
                assign acc_in   = (bus.in_mode == MODE_AND);
                assign found_in = 1'b0;
                assign idx_in   = '0;
            end else begin : link_g
                assign din      = stage_g[gi-1].carry_g.rem_q;
                assign valid_in = stage_g[gi-1].valid_q;
                assign mode_in  = stage_g[gi-1].mode_q;
                assign acc_in   = stage_g[gi-1].acc_q;
                assign found_in = stage_g[gi-1].carry_g.found_q;
                assign idx_in   = stage_g[gi-1].idx_q;
            end

            // Readiness ripples back from the output: empty stages always accept
            if (gi == STAGES - 1) begin : tail_rdy_g
                assign ready = !valid_q | bus.out_ready;
            end else begin : mid_rdy_g
                assign ready = !valid_q | stage_g[gi+1].ready;
            end

            // Fold this stage's bits in ascending order; only the first break is kept
            always_comb begin
                acc_d   = acc_in;
                found_d = found_in;
                idx_d   = idx_in;
                for (int j = 0; j < NB; j++) begin
                    case (mode_in)
                        MODE_AND: begin
                            if (!found_d && !din[j]) begin
                                found_d = 1'b1;
                                idx_d   = IW'(LO + j);
                            end
                            acc_d = acc_d & din[j];
                        end
                        MODE_OR: begin
                            if (!found_d && din[j]) begin
                                found_d = 1'b1;
                                idx_d   = IW'(LO + j);
                            end
                            acc_d = acc_d | din[j];
                        end
                        default: acc_d = acc_d ^ din[j];
                    endcase
                end
            end

            // The final stage resolves "no break seen" to LENGTH so out_idx is final
            assign idx_load = (gi == STAGES - 1) ? (found_d ? idx_d : IW'(LENGTH)) : idx_d;

            // Stage state advances only while this stage is allowed to move
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    mode_q  <= 2'b00;
                    acc_q   <= 1'b0;
                    idx_q   <= '0;
                end else if (ready) begin
                    valid_q <= valid_in;
                    mode_q  <= mode_in;
                    acc_q   <= acc_d;
                    idx_q   <= idx_load;
                end
            end

            if (REM > 0) begin : carry_g
                logic [REM-1:0] rem_q;
                logic           found_q;

                // Unfolded upper bits and the break flag travel on to the next stage
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        rem_q   <= '0;
                        found_q <= 1'b0;
                    end else if (ready) begin
                        rem_q   <= din[LENGTH-LO-1:NB];
                        found_q <= found_d;
                    end
                end
            end
        end
    endgenerate

    assign bus.in_ready  = stage_g[0].ready;
    assign bus.out_valid = stage_g[STAGES-1].valid_q;
    assign bus.out_mode  = stage_g[STAGES-1].mode_q;
    assign bus.out_idx   = stage_g[STAGES-1].idx_q;
    // XNOR is folded as XOR and inverted only at the very end
    assign bus.out_y     = (stage_g[STAGES-1].mode_q == MODE_XNOR) ? ~stage_g[STAGES-1].acc_q
                                                                   :  stage_g[STAGES-1].acc_q;
endmodule
